// File: rtl/fifo_sync_param_if.sv
// Handshake, data and status bundle for fifo_sync_param.
// The producer/consumer side uses the master modport; the FIFO uses the slave modport.
interface fifo_sync_param_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] buf_in;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W:0]   uH;
  logic [ADDR_W:0]   uL;
  logic              err_clr;
  logic [DATA_W-1:0] buf_out;
  logic              out_valid;
  logic              buf_empty;
  logic              buf_full;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   fifo_counter;
  logic              overflow;
  logic              underflow;

  modport master (
    output buf_in, wr_en, rd_en, uH, uL, err_clr,
    input  buf_out, out_valid, buf_empty, buf_full, almost_full, almost_empty,
           fifo_counter, overflow, underflow
  );

  modport slave (
    input  buf_in, wr_en, rd_en, uH, uL, err_clr,
    output buf_out, out_valid, buf_empty, buf_full, almost_full, almost_empty,
           fifo_counter, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have one clock of latency.
module fifo_sync_param #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_sync_param_if.slave   bus
);
  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow_q;
  logic              underflow_q;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic overflow_evt;
  logic underflow_evt;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push.
  assign empty         = (count == '0);
  assign full          = (count == FULL_COUNT);
  assign pop           = bus.rd_en && !empty;
  assign push          = bus.wr_en && (!full || pop);
  assign overflow_evt  = bus.wr_en && full && !pop;
  assign underflow_evt = bus.rd_en && empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A fresh error in the clearing cycle keeps the flag set.
      overflow_q  <= overflow_evt  || (overflow_q  && !bus.err_clr);
      underflow_q <= underflow_evt || (underflow_q && !bus.err_clr);
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers and counter is what empties the FIFO.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= bus.buf_in;
  end

`ifdef FIFO_FWFT_EN
  assign bus.buf_out   = mem[rd_ptr];
  assign bus.out_valid = !empty;
`else
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pop;
      if (pop) dout_q <= mem[rd_ptr];
    end
  end

  assign bus.buf_out   = dout_q;
  assign bus.out_valid = valid_q;
`endif

  assign bus.buf_empty    = empty;
  assign bus.buf_full     = full;
  assign bus.almost_full  = (count >= bus.uH);
  assign bus.almost_empty = (count <= bus.uL);
  assign bus.fifo_counter = count;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
